// File: rtl/core101_pkg.sv
// Shared core101 definitions: PC source and fault encodings, fetch FSM states and the NOP word.
// The control unit imports the same package, so encodings stay consistent across the core.
package core101_pkg;

  typedef enum logic [1:0] {
    PC_SRC_PLUS4  = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_RESET  = 2'b11
  } pc_src_t;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_BUS      = 2'b10
  } fault_t;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH_REQ  = 2'b01,
    FETCH_WAIT = 2'b10,
    FETCH_DONE = 2'b11
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic        vld;
    pc_src_t     src;
    logic [31:0] target;
  } pc_pend_t;

  // Plain 32-bit add; the carry out of bit 31 is dropped so the PC wraps.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Control and instruction-memory signals of the fetch unit; master is the fetch unit itself,
// slave is the surrounding core (control unit, execute stage, memory).
interface fetch_unit_if;

  logic        pc_set_val_in;
  logic [1:0]  pc_src_in;
  logic        ir_set_val_in;
  logic [31:0] branch_target_in;
  logic [31:0] jump_target_in;
  logic        imem_req_valid_out;
  logic        imem_req_ready_in;
  logic [31:0] imem_addr_out;
  logic        imem_resp_valid_in;
  logic [31:0] imem_resp_data_in;
  logic        imem_resp_err_in;
  logic [31:0] pc_out;
  logic [31:0] ir_out;
  logic        fetch_busy_out;
  logic        fetch_done_out;
  logic [1:0]  fetch_fault_out;

  modport master (
    input  pc_set_val_in, pc_src_in, ir_set_val_in, branch_target_in, jump_target_in,
    input  imem_req_ready_in, imem_resp_valid_in, imem_resp_data_in, imem_resp_err_in,
    output imem_req_valid_out, imem_addr_out, pc_out, ir_out,
    output fetch_busy_out, fetch_done_out, fetch_fault_out
  );

  modport slave (
    output pc_set_val_in, pc_src_in, ir_set_val_in, branch_target_in, jump_target_in,
    output imem_req_ready_in, imem_resp_valid_in, imem_resp_data_in, imem_resp_err_in,
    input  imem_req_valid_out, imem_addr_out, pc_out, ir_out,
    input  fetch_busy_out, fetch_done_out, fetch_fault_out
  );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC select (PC+4 / branch / jump with bit0 cleared / reset vector) and
// word-alignment check of the current PC; zero latency, no handshake.
module pc_next_sel
  import core101_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic [31:0] pc,
  input  pc_src_t     src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic [31:0] next_pc,
  output logic        pc_misaligned
);

  always_comb begin
    next_pc = pc_plus4(pc);
    case (src)
      PC_SRC_PLUS4:  next_pc = pc_plus4(pc);
      PC_SRC_BRANCH: next_pc = branch_target;
      PC_SRC_JUMP:   next_pc = {jump_target[31:1], 1'b0};
      PC_SRC_RESET:  next_pc = RESET_VECTOR;
      default:       next_pc = pc_plus4(pc);
    endcase
  end

  assign pc_misaligned = |pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC/IR registers plus IDLE->REQ->WAIT->DONE fetch FSM; 3 cycles minimum from
// ir_set to done. Stalls in REQ while imem is not ready and in WAIT until a response arrives.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD     = core101_pkg::NOP_WORD
) (
  input  logic         fetch_unit_clock_in,
  input  logic         fetch_unit_reset_in,
  fetch_unit_if.master bus
);
  import core101_pkg::*;

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  ir;
  fault_t       fault;
  pc_pend_t     pend;
  logic         fetch_defer;
  logic         resp_got;
  logic         req_vld;
  logic         busy;
  logic         done;

  pc_src_t      live_src;
  pc_src_t      sel_src;
  logic [31:0]  sel_branch;
  logic [31:0]  sel_jump;
  logic [31:0]  next_pc;
  logic         pc_misaligned;
  logic         fetch_req;
  logic         resp_take;
  logic [31:0]  resp_word;
  fault_t       resp_fault;

  assign live_src = pc_src_t'(bus.pc_src_in);

  // A PC request in the same cycle as DONE entry beats the stored pending entry.
  assign sel_src    = bus.pc_set_val_in ? live_src             : pend.src;
  assign sel_branch = bus.pc_set_val_in ? bus.branch_target_in : pend.target;
  assign sel_jump   = bus.pc_set_val_in ? bus.jump_target_in   : pend.target;

  pc_next_sel #(
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_next_sel (
    .pc            (pc),
    .src           (sel_src),
    .branch_target (sel_branch),
    .jump_target   (sel_jump),
    .next_pc       (next_pc),
    .pc_misaligned (pc_misaligned)
  );

  assign fetch_req = bus.ir_set_val_in || fetch_defer;

  // Responses count only from the request handshake cycle onward, and only once per fetch.
  assign resp_take = bus.imem_resp_valid_in &&
                     (((state == FETCH_REQ) && bus.imem_req_ready_in) ||
                      ((state == FETCH_WAIT) && !resp_got));

  assign resp_word  = bus.imem_resp_err_in ? NOP_WORD  : bus.imem_resp_data_in;
  assign resp_fault = bus.imem_resp_err_in ? FAULT_BUS : FAULT_NONE;

  always_ff @(posedge fetch_unit_clock_in or negedge fetch_unit_reset_in) begin
    if (!fetch_unit_reset_in) begin
      state       <= FETCH_IDLE;
      pc          <= RESET_VECTOR;
      ir          <= NOP_WORD;
      fault       <= FAULT_NONE;
      pend        <= '0;
      fetch_defer <= 1'b0;
      resp_got    <= 1'b0;
      req_vld     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;

      if (resp_take) begin
        ir       <= resp_word;
        fault    <= resp_fault;
        resp_got <= 1'b1;
      end

      case (state)
        FETCH_IDLE: begin
          if (bus.pc_set_val_in) begin
            pc <= next_pc;
          end
          // A fetch coinciding with a PC update is replayed next cycle against the new PC.
          fetch_defer <= fetch_req && bus.pc_set_val_in;
          if (fetch_req && !bus.pc_set_val_in) begin
            if (pc_misaligned) begin
              done  <= 1'b1;
              fault <= FAULT_MISALIGN;
              ir    <= NOP_WORD;
            end else begin
              state   <= FETCH_REQ;
              req_vld <= 1'b1;
              busy    <= 1'b1;
              fault   <= FAULT_NONE;
            end
          end
        end

        FETCH_REQ: begin
          if (bus.pc_set_val_in) begin
            pend.vld    <= 1'b1;
            pend.src    <= live_src;
            pend.target <= (live_src == PC_SRC_JUMP) ? bus.jump_target_in : bus.branch_target_in;
          end
          if (bus.imem_req_ready_in) begin
            state   <= FETCH_WAIT;
            req_vld <= 1'b0;
          end
        end

        FETCH_WAIT: begin
          if (bus.pc_set_val_in) begin
            pend.vld    <= 1'b1;
            pend.src    <= live_src;
            pend.target <= (live_src == PC_SRC_JUMP) ? bus.jump_target_in : bus.branch_target_in;
          end
          if (resp_got || bus.imem_resp_valid_in) begin
            state    <= FETCH_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            resp_got <= 1'b0;
            pend     <= '0;
            if (bus.pc_set_val_in || pend.vld) begin
              pc <= next_pc;
            end
          end
        end

        FETCH_DONE: begin
          state <= FETCH_IDLE;
          if (bus.pc_set_val_in) begin
            pc <= next_pc;
          end
        end

        default: state <= FETCH_IDLE;
      endcase
    end
  end

  assign bus.imem_req_valid_out = req_vld;
  assign bus.imem_addr_out      = pc;
  assign bus.pc_out             = pc;
  assign bus.ir_out             = ir;
  assign bus.fetch_busy_out     = busy;
  assign bus.fetch_done_out     = done;
  assign bus.fetch_fault_out    = fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed tables, multi-cycle corner sequences and random fetches.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_VECTOR (32'h0000_0000),
    .NOP_WORD     (NOP)
  ) dut (
    .fetch_unit_clock_in (clk),
    .fetch_unit_reset_in (rst_n),
    .bus                 (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [1:0]  m_fault;

  typedef struct {
    logic [31:0] start;
    logic [1:0]  src;
    logic [31:0] br;
    logic [31:0] jmp;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [1:0] src, input logic [31:0] pc,
                                           input logic [31:0] br, input logic [31:0] jmp);
    case (src)
      2'b00:   return pc + 32'd4;
      2'b01:   return br;
      2'b10:   return jmp & 32'hFFFF_FFFE;
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic clear_inputs();
    bus.pc_set_val_in      = 1'b0;
    bus.pc_src_in          = 2'b00;
    bus.ir_set_val_in      = 1'b0;
    bus.branch_target_in   = 32'h0;
    bus.jump_target_in     = 32'h0;
    bus.imem_req_ready_in  = 1'b0;
    bus.imem_resp_valid_in = 1'b0;
    bus.imem_resp_data_in  = 32'h0;
    bus.imem_resp_err_in   = 1'b0;
  endtask

  task automatic pc_set_idle(input logic [1:0] src, input logic [31:0] br, input logic [31:0] jmp);
    bus.pc_set_val_in    = 1'b1;
    bus.pc_src_in        = src;
    bus.branch_target_in = br;
    bus.jump_target_in   = jmp;
    @(negedge clk);
    bus.pc_set_val_in = 1'b0;
    m_pc = ref_next(src, m_pc, br, jmp);
    chk("pc_set_idle", bus.pc_out, m_pc);
  endtask

  // w: cycles of ready low; d: response delay after the handshake cycle; inj: busy cycle of a PC request.
  task automatic fetch(input string nm, input int w, input int d, input logic [31:0] data,
                       input logic err, input int inj, input logic [1:0] isrc,
                       input logic [31:0] ibr, input logic [31:0] ijmp);
    logic [31:0] pc0;
    logic [31:0] exp_pc;
    logic        stable_bad;
    logic        addr_bad;
    int          hs;
    int          wcnt;
    int          lat;
    int          exp_lat;
    pc0        = m_pc;
    exp_pc     = m_pc;
    stable_bad = 1'b0;
    addr_bad   = 1'b0;
    hs         = -1;
    wcnt       = 0;
    lat        = -1;
    exp_lat    = 2 + w + ((d < 1) ? 1 : d);
    bus.ir_set_val_in = 1'b1;
    @(negedge clk);
    bus.ir_set_val_in = 1'b0;
    chk({nm, "_start_fault"}, {30'b0, bus.fetch_fault_out}, 32'h0);
    chk({nm, "_req_valid"}, {31'b0, bus.imem_req_valid_out}, 32'h1);
    for (int c = 1; c <= 64; c++) begin
      if (bus.fetch_done_out) begin
        lat = c;
        break;
      end
      bus.imem_req_ready_in  = 1'b0;
      bus.imem_resp_valid_in = 1'b0;
      bus.pc_set_val_in      = 1'b0;
      bus.ir_set_val_in      = 1'($urandom_range(0, 1));
      if (hs < 0 && bus.imem_req_valid_out) begin
        if (bus.imem_addr_out !== pc0) addr_bad = 1'b1;
        if (wcnt == w) begin
          bus.imem_req_ready_in = 1'b1;
          hs = c;
        end else begin
          wcnt++;
        end
      end
      if (hs >= 0 && c == hs + d) begin
        bus.imem_resp_valid_in = 1'b1;
        bus.imem_resp_data_in  = data;
        bus.imem_resp_err_in   = err;
      end
      if (c == inj) begin
        bus.pc_set_val_in    = 1'b1;
        bus.pc_src_in        = isrc;
        bus.branch_target_in = ibr;
        bus.jump_target_in   = ijmp;
        exp_pc = ref_next(isrc, pc0, ibr, ijmp);
      end
      if (bus.pc_out !== pc0 || bus.fetch_busy_out !== 1'b1) stable_bad = 1'b1;
      @(negedge clk);
    end
    clear_inputs();
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL %s_timeout: no done pulse within 64 cycles, expected one after %0d", nm, exp_lat);
    end else begin
      m_ir    = err ? NOP : data;
      m_fault = err ? 2'b10 : 2'b00;
      m_pc    = exp_pc;
      chk({nm, "_latency"}, lat, exp_lat);
      chk({nm, "_ir"}, bus.ir_out, m_ir);
      chk({nm, "_fault"}, {30'b0, bus.fetch_fault_out}, {30'b0, m_fault});
      chk({nm, "_pc_at_done"}, bus.pc_out, m_pc);
      chk({nm, "_pc_stable_busy"}, {31'b0, stable_bad}, 32'h0);
      chk({nm, "_req_addr"}, {31'b0, addr_bad}, 32'h0);
      @(negedge clk);
      chk({nm, "_done_one_cycle"}, {31'b0, bus.fetch_done_out}, 32'h0);
      chk({nm, "_idle_after"}, {31'b0, bus.fetch_busy_out | bus.imem_req_valid_out}, 32'h0);
      chk({nm, "_fault_hold"}, {30'b0, bus.fetch_fault_out}, {30'b0, m_fault});
    end
  endtask

  task automatic misaligned_fetch(input string nm);
    bus.ir_set_val_in = 1'b1;
    @(negedge clk);
    bus.ir_set_val_in = 1'b0;
    m_ir    = NOP;
    m_fault = 2'b01;
    chk({nm, "_done"}, {31'b0, bus.fetch_done_out}, 32'h1);
    chk({nm, "_no_req"}, {31'b0, bus.imem_req_valid_out | bus.fetch_busy_out}, 32'h0);
    chk({nm, "_fault"}, {30'b0, bus.fetch_fault_out}, {30'b0, m_fault});
    chk({nm, "_ir"}, bus.ir_out, m_ir);
    @(negedge clk);
    chk({nm, "_after"}, {31'b0, bus.fetch_done_out | bus.imem_req_valid_out}, 32'h0);
  endtask

  initial begin
    tbl[0] = '{32'h0000_0100, 2'b00, 32'h0, 32'h0, 32'h0000_0104};
    tbl[1] = '{32'hFFFF_FFFC, 2'b00, 32'h0, 32'h0, 32'h0000_0000};
    tbl[2] = '{32'h0000_0100, 2'b01, 32'h0000_0200, 32'h0, 32'h0000_0200};
    tbl[3] = '{32'h0000_0000, 2'b10, 32'h0, 32'h0000_0303, 32'h0000_0302};
    tbl[4] = '{32'h1234_5678, 2'b11, 32'h0, 32'h0, 32'h0000_0000};
    tbl[5] = '{32'h0000_0000, 2'b10, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[6] = '{32'h0000_0010, 2'b01, 32'hABCD_0000, 32'h0, 32'hABCD_0000};

    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    m_pc = 32'h0; m_ir = NOP; m_fault = 2'b00;
    chk("reset_pc", bus.pc_out, m_pc);
    chk("reset_ir", bus.ir_out, m_ir);
    chk("reset_flags", {29'b0, bus.imem_req_valid_out, bus.fetch_busy_out, bus.fetch_done_out}, 32'h0);
    chk("reset_fault", {30'b0, bus.fetch_fault_out}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    fetch("first_fetch", 0, 0, 32'h0050_0093, 1'b0, 0, 2'b00, 32'h0, 32'h0);

    for (int i = 0; i < 7; i++) begin
      pc_set_idle(2'b01, tbl[i].start, 32'h0);
      pc_set_idle(tbl[i].src, tbl[i].br, tbl[i].jmp);
      chk($sformatf("pc_table_%0d", i), bus.pc_out, tbl[i].exp);
    end

    pc_set_idle(2'b01, 32'h0000_0100, 32'h0);
    fetch("pend_branch", 0, 5, 32'h00a0_0113, 1'b0, 2, 2'b01, 32'h0000_0200, 32'h0);
    chk("pend_branch_pc", bus.pc_out, 32'h0000_0200);

    pc_set_idle(2'b10, 32'h0, 32'h0000_0303);
    chk("jump_bit0", bus.pc_out, 32'h0000_0302);
    misaligned_fetch("misaligned");

    pc_set_idle(2'b11, 32'h0, 32'h0);
    fetch("bus_err", 1, 1, 32'hDEAD_BEEF, 1'b1, 0, 2'b00, 32'h0, 32'h0);
    chk("bus_err_ir", bus.ir_out, 32'h0000_0013);

    // PC update and fetch request in the same IDLE cycle.
    pc_set_idle(2'b01, 32'h0000_0100, 32'h0);
    bus.pc_set_val_in    = 1'b1;
    bus.pc_src_in        = 2'b01;
    bus.branch_target_in = 32'h0000_0400;
    bus.ir_set_val_in    = 1'b1;
    @(negedge clk);
    clear_inputs();
    chk("simul_pc_first", bus.pc_out, 32'h0000_0400);
    chk("simul_no_req_yet", {31'b0, bus.imem_req_valid_out}, 32'h0);
    @(negedge clk);
    chk("simul_req", {31'b0, bus.imem_req_valid_out}, 32'h1);
    chk("simul_addr", bus.imem_addr_out, 32'h0000_0400);
    bus.imem_req_ready_in  = 1'b1;
    bus.imem_resp_valid_in = 1'b1;
    bus.imem_resp_data_in  = 32'h0020_0193;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    chk("simul_done", {31'b0, bus.fetch_done_out}, 32'h1);
    chk("simul_ir", bus.ir_out, 32'h0020_0193);
    m_pc = 32'h0000_0400; m_ir = 32'h0020_0193; m_fault = 2'b00;
    @(negedge clk);

    // Reset while waiting for a response, then a stray late response.
    pc_set_idle(2'b01, 32'h0000_0180, 32'h0);
    bus.ir_set_val_in = 1'b1;
    @(negedge clk);
    bus.ir_set_val_in     = 1'b0;
    bus.imem_req_ready_in = 1'b1;
    @(negedge clk);
    bus.imem_req_ready_in = 1'b0;
    chk("rst_wait_busy", {31'b0, bus.fetch_busy_out}, 32'h1);
    rst_n = 1'b0;
    #1;
    m_pc = 32'h0; m_ir = NOP; m_fault = 2'b00;
    chk("rst_wait_pc", bus.pc_out, m_pc);
    chk("rst_wait_ir", bus.ir_out, m_ir);
    chk("rst_wait_flags", {29'b0, bus.imem_req_valid_out, bus.fetch_busy_out, bus.fetch_done_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.imem_resp_valid_in = 1'b1;
    bus.imem_resp_data_in  = 32'hDEAD_BEEF;
    @(negedge clk);
    clear_inputs();
    chk("stray_ir", bus.ir_out, m_ir);
    chk("stray_pc", bus.pc_out, m_pc);
    chk("stray_flags", {28'b0, bus.fetch_fault_out, bus.fetch_busy_out, bus.fetch_done_out}, 32'h0);

    for (int it = 0; it < 30; it++) begin
      logic [1:0]  src;
      logic [31:0] br;
      logic [31:0] jmp;
      src = 2'($urandom_range(0, 3));
      br  = $urandom & 32'hFFFF_FFFC;
      jmp = ($urandom & 32'hFFFF_FFFD) | (($urandom_range(0, 5) == 0) ? 32'h2 : 32'h0);
      pc_set_idle(src, br, jmp);
      if (m_pc[1:0] != 2'b00) begin
        misaligned_fetch($sformatf("rnd%0d_mis", it));
      end else begin
        fetch($sformatf("rnd%0d", it), $urandom_range(0, 3), $urandom_range(0, 5), $urandom,
              1'($urandom_range(0, 4) == 0),
              ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0,
              2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000, PC value loaded on reset and on pc_src=2'b11.
REQ-002 Parameter NOP_WORD, 32'h0000_0013, IR value after reset and after a faulted fetch.
REQ-003 fetch_unit_clock_in  input  1  single clock; all state updates on its rising edge.
REQ-004 fetch_unit_reset_in  input  1  reset, asynchronous and active-low.
REQ-005 pc_set_val_in  input  1  from control unit; request to load the PC from the source selected by pc_src_in.
REQ-006 pc_src_in  input  2  PC source: 00 PC+4, 01 branch_target_in, 10 jump_target_in with bit0 cleared, 11 RESET_VECTOR.
REQ-007 ir_set_val_in  input  1  from control unit; start fetch of the word at the current PC.
REQ-008 branch_target_in, jump_target_in  input  32 each  execute-stage targets.
REQ-009 imem_req_valid_out / imem_req_ready_in  output / input  1 / 1  memory request handshake.
REQ-010 imem_addr_out  output  32  request address, equal to PC while the request is valid.
REQ-011 imem_resp_valid_in, imem_resp_data_in[31:0], imem_resp_err_in  input  1/32/1  memory response.
REQ-012 pc_out, ir_out  output  32 each  current PC and instruction register.
REQ-013 fetch_busy_out, fetch_done_out, fetch_fault_out[1:0]  output  status: busy level, 1-cycle done pulse, fault code 00 none / 01 misaligned / 10 bus error.

Function
REQ-014 The FSM SHALL have states IDLE, REQ, WAIT, DONE.
REQ-015 IDLE->REQ on ir_set_val_in=1 when PC[1:0]=00; when PC[1:0]!=00, the block SHALL stay in IDLE, issue no request, pulse fetch_done_out, set fault 01 and load IR with NOP_WORD.
REQ-016 In REQ, imem_req_valid_out SHALL be 1 and the address stable until imem_req_ready_in=1; REQ->WAIT on handshake.
REQ-017 A response with valid=1 arriving in the handshake cycle or later SHALL be accepted; the block SHALL then go WAIT->DONE.
REQ-018 On response with err=0, IR SHALL load imem_resp_data_in and fault SHALL be 00; with err=1, IR SHALL load NOP_WORD and fault SHALL be 10.
REQ-019 DONE SHALL last exactly one cycle with fetch_done_out=1, then return to IDLE.
REQ-020 Minimum latency from ir_set_val_in to fetch_done_out SHALL be 3 cycles, with ready and response both immediate.
REQ-021 fetch_busy_out SHALL be 1 in REQ and WAIT only.
REQ-022 In IDLE or DONE, pc_set_val_in SHALL update the PC on the next edge.
REQ-023 In REQ or WAIT, pc_set_val_in SHALL latch {src, target} into a one-entry pending register; the PC SHALL change only on entry to DONE, and a later request SHALL overwrite the pending entry.
REQ-024 Simultaneous pc_set_val_in and ir_set_val_in in IDLE: the PC update SHALL take effect first, and the fetch SHALL use the new PC one cycle later.
REQ-025 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); the carry SHALL be discarded.
REQ-026 ir_set_val_in outside IDLE SHALL be ignored.
REQ-027 fetch_fault_out SHALL hold its value until the next fetch start or fault.

Reset
REQ-028 On reset assertion, the block SHALL go to IDLE asynchronously, with PC=RESET_VECTOR, IR=NOP_WORD, pending entry cleared, all valid/busy/done outputs 0 and fault 00.
REQ-029 Reset in REQ/WAIT SHALL abandon the transaction, and a late response after release SHALL be ignored, because resp_valid is only accepted in REQ/WAIT.

Structure
REQ-030 The PC source encodings, fault codes, FSM state encodings and NOP_WORD SHALL live in shared package core101_pkg and be reused by the control unit.
REQ-031 One sub-module, pc_next_sel, SHALL hold the combinational next-PC mux, bit0 clearing and alignment check.

Verification
REQ-032 Reset release, then ir_set_val pulse, ready=1, resp same cycle with data 32'h00500093 -> IR=32'h00500093, done pulse 3 cycles after the request, PC=0.
REQ-033 PC=32'h100, pc_set src=00 -> PC=32'h104; PC=32'hFFFF_FFFC, src=00 -> PC=0.
REQ-034 pc_set src=01, target 32'h200, during WAIT with a 5-cycle response -> PC stays 32'h100 until DONE, then becomes 32'h200.
REQ-035 jump_target 32'h303, src=10 -> PC=32'h302, then ir_set -> no imem request, fault=01, IR=NOP_WORD.
REQ-036 Response with err=1 -> IR=32'h00000013, fault=10; assert reset in WAIT -> IDLE, PC=RESET_VECTOR, and a stray response after release changes nothing.
